// File: rtl/cardinal_pkg.sv
// Shared definitions for the cardinal ring: packet field positions,
// route port encodings and default widths. The NIC and the output
// arbiters import the same package.
package cardinal_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_HOP_W  = 8;

  localparam int VC_BIT  = 63;
  localparam int DIR_BIT = 62;
  localparam int HOP_MSB = 55;
  localparam int HOP_LSB = 48;

  typedef enum logic [2:0] {
    PORT_NONE = 3'b000,
    PORT_CW   = 3'b001,
    PORT_CCW  = 3'b010,
    PORT_PE   = 3'b100
  } port_e;

  // Route of a stored packet: an exhausted hop count ejects to the PE,
  // otherwise the direction bit picks the ring.
  function automatic port_e route_of(input logic dir, input logic [DEF_HOP_W-1:0] hop);
    if (hop == '0)
      return PORT_PE;
    else if (dir)
      return PORT_CCW;
    else
      return PORT_CW;
  endfunction

endpackage

// File: rtl/cardinal_router_input_port_if.sv
// Link-side bundle of the input port: upstream si/ri/di handshake,
// route request towards the output arbiters, phase and error flag.
interface cardinal_router_input_port_if #(
  parameter int DATA_W = cardinal_pkg::DEF_DATA_W
);
  logic              polarity;
  logic              net_si;
  logic              net_ri;
  logic [DATA_W-1:0] net_di;
  logic [2:0]        req;
  logic [DATA_W-1:0] fwd_do;
  logic              gnt;
  logic              err;

  // Environment side: upstream sender, arbiter and phase generator.
  modport master (
    output polarity, net_si, net_di, gnt,
    input  net_ri, req, fwd_do, err
  );

  // Router input port side.
  modport slave (
    input  polarity, net_si, net_di, gnt,
    output net_ri, req, fwd_do, err
  );
endinterface

// File: rtl/cardinal_vc_slot.sv
// One-entry virtual-channel buffer: data register plus full flag.
// Write loads data and sets full; clear only drops the full flag.
module cardinal_vc_slot #(
  parameter int DATA_W = cardinal_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] data,
  output logic              full
);

  // Data capture and occupancy; write wins if both strobes ever coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
      full <= 1'b0;
    end else if (wr) begin
      data <= din;
      full <= 1'b1;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cardinal_router_input_port.sv
// Per-link input stage of the cardinal ring router. Upstream writes the
// VC slot matching the current polarity; the opposite slot is routed and
// offered to the output arbiters with its hop count halved.
module cardinal_router_input_port #(
  parameter int DATA_W = cardinal_pkg::DEF_DATA_W,
  parameter int HOP_W  = cardinal_pkg::DEF_HOP_W
) (
  input  logic                         clk,
  input  logic                         reset,
  cardinal_router_input_port_if.slave  port_if
);
  import cardinal_pkg::*;

  logic [1:0]        full;
  logic [1:0]        wr;
  logic [1:0]        clr;
  logic [DATA_W-1:0] slot_even;
  logic [DATA_W-1:0] slot_odd;
  logic              acc_vc;
  logic              drn_vc;
  logic              vc_match;
  logic              accept;
  logic              mismatch;
  logic              drn_full;
  logic [DATA_W-1:0] drn_data;
  logic [HOP_W-1:0]  drn_hop;
  port_e             route;
  logic [DATA_W-1:0] fwd;
  logic              err_q;

  assign acc_vc   = port_if.polarity;
  assign drn_vc   = ~port_if.polarity;
  assign vc_match = (port_if.net_di[VC_BIT] == acc_vc);

  // Accept/drop decision for the upstream slot and drain strobe for the other.
  always_comb begin
    wr       = 2'b00;
    clr      = 2'b00;
    accept   = port_if.net_si && !full[acc_vc] && vc_match;
    mismatch = port_if.net_si && !full[acc_vc] && !vc_match;
    wr[acc_vc]  = accept;
    clr[drn_vc] = port_if.gnt && full[drn_vc];
  end

  cardinal_vc_slot #(.DATA_W(DATA_W)) u_slot_even (
    .clk  (clk),
    .reset(reset),
    .wr   (wr[0]),
    .clr  (clr[0]),
    .din  (port_if.net_di),
    .data (slot_even),
    .full (full[0])
  );

  cardinal_vc_slot #(.DATA_W(DATA_W)) u_slot_odd (
    .clk  (clk),
    .reset(reset),
    .wr   (wr[1]),
    .clr  (clr[1]),
    .din  (port_if.net_di),
    .data (slot_odd),
    .full (full[1])
  );

  assign drn_full = full[drn_vc];
  assign drn_data = drn_vc ? slot_odd : slot_even;
  assign drn_hop  = drn_data[HOP_MSB:HOP_LSB];

  // Route and hop rewrite for the draining slot; an empty slot presents zeros.
  always_comb begin
    route = PORT_NONE;
    fwd   = '0;
    if (drn_full) begin
      route = route_of(drn_data[DIR_BIT], drn_hop);
      fwd   = drn_data;
      if (route != PORT_PE)
        fwd[HOP_MSB:HOP_LSB] = drn_hop >> 1;
    end
  end

  // Sticky protocol error: a send whose VC bit disagrees with the phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_q <= 1'b0;
    else if (mismatch)
      err_q <= 1'b1;
  end

  assign port_if.net_ri = ~full[acc_vc];
  assign port_if.req    = route;
  assign port_if.fwd_do = fwd;
  assign port_if.err    = err_q;

endmodule

// File: tb/tb_cardinal_router_input_port.sv
// Directed bench for cardinal_router_input_port. Each step sets the cycle's
// inputs shortly after a rising edge and checks outputs before the next one.
module tb_cardinal_router_input_port;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  cardinal_router_input_port_if #(.DATA_W(64)) ifc ();

  cardinal_router_input_port dut (
    .clk    (clk),
    .reset  (reset),
    .port_if(ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one cycle: flip phase, clear strobes, let combinational outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
    ifc.polarity = ~ifc.polarity;
    ifc.net_si   = 1'b0;
    ifc.gnt      = 1'b0;
    ifc.net_di   = '0;
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset        = 1'b1;
    ifc.polarity = 1'b0;
    ifc.net_si   = 1'b0;
    ifc.gnt      = 1'b0;
    ifc.net_di   = '0;
    #2 reset = 1'b0;
    #1;

    // reset state
    check("rst_ri_p0", ifc.net_ri, 1);
    check("rst_req", ifc.req, 0);
    check("rst_err", ifc.err, 0);
    check("rst_fwd", ifc.fwd_do, 0);
    ifc.polarity = 1'b1;
    #1;
    check("rst_ri_p1", ifc.net_ri, 1);
    ifc.polarity = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_req", ifc.req, 0);
      check("idle_ri", ifc.net_ri, 1);
    end
    // four ticks from 0 leave polarity at 0

    // CW forward
    check("cw_pol", ifc.polarity, 0);
    ifc.net_si = 1'b1;
    ifc.net_di = 64'h0003_0000_DEAD_BEEF;
    check("cw_ri", ifc.net_ri, 1);
    tick();  // pol 1
    check("cw_req", ifc.req, 3'b001);
    check("cw_fwd", ifc.fwd_do, 64'h0001_0000_DEAD_BEEF);
    ifc.gnt = 1'b1;
    tick();  // pol 0
    check("cw_ri_after", ifc.net_ri, 1);
    check("cw_req_after", ifc.req, 0);

    // CCW into slot 1, then PE into slot 0 while slot 1 drains
    tick();  // pol 1
    ifc.net_si = 1'b1;
    ifc.net_di = 64'hC002_0000_0000_0001;
    tick();  // pol 0
    check("ccw_req", ifc.req, 3'b010);
    check("ccw_fwd", ifc.fwd_do, 64'hC001_0000_0000_0001);
    check("ccw_ri0", ifc.net_ri, 1);
    ifc.gnt    = 1'b1;
    ifc.net_si = 1'b1;
    ifc.net_di = 64'h0000_0000_0000_00AA;
    tick();  // pol 1
    check("pe_req", ifc.req, 3'b100);
    check("pe_fwd", ifc.fwd_do, 64'h0000_0000_0000_00AA);
    check("ccw_freed_ri1", ifc.net_ri, 1);
    ifc.gnt = 1'b1;
    tick();  // pol 0
    check("pe_done_req", ifc.req, 0);
    check("pe_done_ri", ifc.net_ri, 1);

    // Backpressure on slot 0
    ifc.net_si = 1'b1;
    ifc.net_di = 64'h0005_0000_1234_5678;
    tick();  // pol 1
    check("bp_req1", ifc.req, 3'b001);
    check("bp_fwd1", ifc.fwd_do, 64'h0002_0000_1234_5678);
    tick();  // pol 0
    check("bp_ri0", ifc.net_ri, 0);
    ifc.net_si = 1'b1;
    ifc.net_di = 64'h0007_0000_0BAD_F00D;
    tick();  // pol 1
    check("bp_err", ifc.err, 0);
    check("bp_req2", ifc.req, 3'b001);
    check("bp_fwd2", ifc.fwd_do, 64'h0002_0000_1234_5678);
    tick();  // pol 0
    check("bp_ri0b", ifc.net_ri, 0);
    tick();  // pol 1
    check("bp_req3", ifc.req, 3'b001);
    check("bp_fwd3", ifc.fwd_do, 64'h0002_0000_1234_5678);
    ifc.gnt = 1'b1;
    tick();  // pol 0
    check("bp_ri_free", ifc.net_ri, 1);

    // VC/polarity mismatch
    check("mm_err_before", ifc.err, 0);
    ifc.net_si = 1'b1;
    ifc.net_di = 64'h8000_0000_0000_0055;
    tick();  // pol 1
    check("mm_err", ifc.err, 1);
    check("mm_req1", ifc.req, 0);
    check("mm_ri1", ifc.net_ri, 1);
    tick();  // pol 0
    check("mm_req0", ifc.req, 0);
    check("mm_ri0", ifc.net_ri, 1);
    check("mm_err_sticky", ifc.err, 1);

    // Simultaneous accept into slot 1 and drain of slot 0
    ifc.net_si = 1'b1;
    ifc.net_di = 64'h0001_0000_0000_0011;
    tick();  // pol 1
    check("sim_req_cw", ifc.req, 3'b001);
    check("sim_fwd_cw", ifc.fwd_do, 64'h0000_0000_0000_0011);
    check("sim_ri1", ifc.net_ri, 1);
    ifc.gnt    = 1'b1;
    ifc.net_si = 1'b1;
    ifc.net_di = 64'h8000_0000_0000_0022;
    tick();  // pol 0
    check("sim_req_pe", ifc.req, 3'b100);
    check("sim_fwd_pe", ifc.fwd_do, 64'h8000_0000_0000_0022);
    check("sim_ri0", ifc.net_ri, 1);
    tick();  // pol 1
    check("sim_ri1_full", ifc.net_ri, 0);
    check("sim_req_empty0", ifc.req, 0);
    tick();  // pol 0, slot 1 still held
    check("hold_req", ifc.req, 3'b100);

    // Asynchronous reset mid-hold
    reset = 1'b0;
    #1;
    check("arst_req", ifc.req, 0);
    check("arst_fwd", ifc.fwd_do, 0);
    check("arst_err", ifc.err, 0);
    check("arst_ri", ifc.net_ri, 1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_rst_req", ifc.req, 0);
    check("post_rst_ri", ifc.net_ri, 1);
    tick();
    check("post_rst_req2", ifc.req, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cardinal_router_input_port.md
# cardinal_router_input_port

Per-link input stage of the cardinal ring router, directly downstream of the NIC (and of neighbouring routers). It accepts packets over the si/ri/di handshake into two one-entry virtual-channel slots (even/odd), selected by the packet VC bit and the router-global polarity. It computes the ring route for each stored packet and presents it to the router's output arbiters with an updated hop field.

## Interface
- DATA_W, 64, packet width
- HOP_W, 8, hop-count field width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- polarity  input  1  router-global phase, toggles every cycle; 0 = even phase
- net_si  input  1  upstream send strobe
- net_ri  output  1  ready for the VC equal to current polarity
- net_di  input  DATA_W  upstream packet
- req  output  3  one-hot route request {pe, ccw, cw} for the draining slot
- fwd_do  output  DATA_W  packet to forward, hop field updated
- gnt  input  1  arbiter grant for the current req
- err  output  1  sticky protocol error (VC/polarity mismatch)

## Operation
- Packet fields: [63] VC, [62] direction (0 = cw, 1 = ccw), [55:48] hop, remaining bits are payload and pass through unchanged.
- Each slot[v] (v = 0/1) holds a DATA_W register and a full flag.
- **External phase (accept).** Upstream may write slot[polarity].
  - net_ri = !full[polarity].
  - Accept on net_si && net_ri && net_di[63] == polarity: store net_di and set full.
  - net_si && net_ri && net_di[63] != polarity: drop the packet, set err (sticky until reset), leave both slots unchanged.
  - net_si while !net_ri: ignored, no error.
- **Internal phase (drain).** Slot q = !polarity is presented downstream.
  - If full[q]:
    - hop == 0: req = 3'b100 (pe).
    - hop != 0 and dir = 0: req = 3'b001 (cw).
    - hop != 0 and dir = 1: req = 3'b010 (ccw).
  - If !full[q]: req = 0.
  - fwd_do = slot[q] with hop replaced by hop >> 1 for cw/ccw, and unchanged for pe. VC and dir bits are unchanged.
  - gnt sampled with req != 0: clear full[q] at the edge.
  - gnt with req == 0: ignored.
- Accept and drain always target different slots, so both may occur at the same edge with no conflict.

## Timing
- Reset values: net_ri = 1 (when polarity is 0 or 1 and both slots are empty), req = 0, fwd_do = 0, err = 0, full[1:0] = 0, slot data = 0.
- net_ri, req and fwd_do are combinational from registered state and polarity. There is no combinational path from net_si/net_di to any output.
- A packet accepted at edge N (polarity p) is presented on req/fwd_do in cycle N+1, when polarity = !p.
- With gnt in that cycle, the slot is free at edge N+1 and net_ri rises in cycle N+2 (polarity p again). Sustained throughput is one packet per VC every two cycles.
- Without gnt, the packet holds and req stays asserted on every cycle where polarity = !p.
- Asynchronous reset assertion mid-operation discards both slots immediately, forces req = 0, and clears err. Deassertion is synchronised by the router top.
- No gnt ever: the slot stays full and net_ri for that VC stays 0. No overflow or loss occurs.

## Structure
- Shared package cardinal_pkg holds: field positions (VC_BIT = 63, DIR_BIT = 62, HOP_MSB/HOP_LSB = 55/48), port one-hot encodings (PORT_CW, PORT_CCW, PORT_PE), and the DATA_W/HOP_W defaults. The NIC and the output arbiters use the same package.
- Sub-module cardinal_vc_slot: one-entry register with a full flag and write/clear strobes, instantiated twice (v = 0, 1). Route compute and hop update stay in the top.

## Test plan
- Reset: with reset = 0, expect net_ri = 1, req = 0, err = 0; after release, toggle polarity for 4 cycles and expect req to stay 0.
- CW forward: in the polarity = 0 cycle send 64'h0003_0000_DEAD_BEEF. Expect acceptance, then in the next cycle req = 001 and fwd_do = 64'h0001_0000_DEAD_BEEF. Apply gnt, then expect net_ri = 1 in the following polarity-0 cycle.
- CCW and PE in parallel:
  - In the polarity = 1 cycle send 64'hC002_0000_0000_0001. Expect req = 010 and fwd_do = 64'hC001_0000_0000_0001.
  - Separately, send hop = 0 packet 64'h0000_0000_0000_00AA at polarity 0. Expect req = 100 with fwd_do unchanged.
- Backpressure: fill slot 0 with gnt held low. Expect req to be reasserted every polarity-1 cycle, net_ri = 0 in every polarity-0 cycle, and a second net_si ignored with no err. Then grant and confirm the original data is delivered.
- Mismatch: at polarity = 0 send a packet with bit 63 = 1. Expect the drop, err = 1 (sticky), and both slots still empty.
- Simultaneous: at the same edge, accept into slot 1 (polarity = 1) and grant-drain slot 0. Expect both to complete. Also assert reset mid-hold and expect req = 0 immediately.
